// File: rtl/spi_slave_if.sv
// spi_slave_if -- serial front end of the SPI memory slave.
//
// Deserializes 10-bit MOSI frames {cmd[1:0], payload[7:0]} (MSB first) into
// rx_data with a one-cycle rx_valid strobe. For read-data frames, it waits
// for the RAM reply (tx_valid/tx_data) and shifts that byte out on MISO,
// MSB first. Bits are sampled once per clk while SS_n is low.
//
// Optional feature macro: SPI_FRAME_ERR_EN
//   When this macro is defined, frame_err pulses for one cycle after a frame
//   is aborted by SS_n rising in WRITE/READ_ADD/READ_DATA. This happens if
//   fewer than 10 bits were received, or if the MISO reply was not finished.
//   When the macro is undefined, frame_err is tied to 0.
//
// Ports:
//   clk        system/SPI clock, rising edge
//   rst        asynchronous active-high reset
//   MOSI       serial data in
//   SS_n       slave select, active low
//   MISO       serial read data out
//   rx_data    assembled 10-bit frame to the RAM
//   rx_valid   one-cycle strobe, rx_data valid
//   tx_data    read byte from the RAM
//   tx_valid   tx_data valid (only accepted while awaiting the reply)
//   frame_err  one-cycle abort strobe
module spi_slave_if #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 MOSI,
  input  logic                 SS_n,
  output logic                 MISO,
  output logic [9:0]           rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 frame_err
);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

  // tx_cnt: 0 = awaiting reply, 1..ADDR_SIZE = bit on MISO, TX_DONE = finished
  localparam int TXW = $clog2(ADDR_SIZE + 2);
  localparam logic [TXW-1:0] TX_LAST = TXW'(ADDR_SIZE);
  localparam logic [TXW-1:0] TX_DONE = TXW'(ADDR_SIZE + 1);

  state_t               state, state_nxt;
  logic                 rd_addr_pending;
  logic [3:0]           bit_cnt;
  logic [8:0]           rx_sh;
  logic [ADDR_SIZE-1:0] tx_sh;
  logic [TXW-1:0]       tx_cnt;

  logic in_frame, abort, shift_en, last_bit, tx_wait, tx_shift;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!SS_n) state_nxt = CHK_CMD;
      CHK_CMD: begin
        if (SS_n)                 state_nxt = IDLE;
        else if (!MOSI)           state_nxt = WRITE;
        else if (rd_addr_pending) state_nxt = READ_DATA;
        else                      state_nxt = READ_ADD;
      end
      default: if (SS_n) state_nxt = IDLE;
    endcase
  end

  // Decoded per-cycle actions
  always_comb begin
    in_frame = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
    abort    = in_frame && SS_n;
    shift_en = in_frame && !SS_n && (bit_cnt < 4'd10);
    last_bit = shift_en && (bit_cnt == 4'd9);
    tx_wait  = (state == READ_DATA) && !SS_n && (bit_cnt == 4'd10) && (tx_cnt == '0);
    tx_shift = (state == READ_DATA) && !SS_n && (tx_cnt != '0) && (tx_cnt <= TX_LAST);
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      MISO            <= 1'b0;
      rx_data         <= '0;
      rx_valid        <= 1'b0;
      rd_addr_pending <= 1'b0;
      bit_cnt         <= '0;
      rx_sh           <= '0;
      tx_sh           <= '0;
      tx_cnt          <= '0;
    end else begin
      rx_valid <= 1'b0;

      if (state == CHK_CMD && !SS_n) begin
        rx_sh   <= {rx_sh[7:0], MOSI};
        bit_cnt <= 4'd1;
        tx_cnt  <= '0;
      end

      if (shift_en) begin
        rx_sh   <= {rx_sh[7:0], MOSI};
        bit_cnt <= bit_cnt + 4'd1;
        if (last_bit) begin
          rx_data  <= {rx_sh, MOSI};
          rx_valid <= 1'b1;
          if (state == READ_ADD) rd_addr_pending <= 1'b1;
        end
      end

      // The first reply bit goes straight to MISO; the shifter holds the remaining bits
      if (tx_wait && tx_valid) begin
        MISO   <= tx_data[ADDR_SIZE-1];
        tx_sh  <= tx_data << 1;
        tx_cnt <= TXW'(1);
      end

      if (tx_shift) begin
        if (tx_cnt == TX_LAST) begin
          MISO            <= 1'b0;
          rd_addr_pending <= 1'b0;
          tx_cnt          <= TX_DONE;
        end else begin
          MISO   <= tx_sh[ADDR_SIZE-1];
          tx_sh  <= tx_sh << 1;
          tx_cnt <= tx_cnt + TXW'(1);
        end
      end

      if (abort) begin
        MISO    <= 1'b0;
        bit_cnt <= '0;
        tx_cnt  <= '0;
      end
    end
  end

`ifdef SPI_FRAME_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      frame_err <= 1'b0;
    else
      frame_err <= abort &&
                   ((bit_cnt != 4'd10) || ((state == READ_DATA) && (tx_cnt != TX_DONE)));
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule
